// File: rtl/ahb_bus_arbiter_if.sv
// Purpose : bundles the two requester ports and the shared AHB-Lite bus of
//           ahb_bus_arbiter into one interface.
// Ports   : master modport = arbiter view (requests and slave response in;
//           done/err/rdata, owner and address/control/wdata out).
//           slave modport  = environment view (requesters plus the response mux).
interface ahb_bus_arbiter_if;
  // requester side
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_write;
  logic [2:0]  m1_size;
  logic [31:0] m1_wdata;
  logic        m0_done;
  logic        m1_done;
  logic        m0_err;
  logic        m1_err;
  logic [31:0] rdata;
  logic        owner;
  // shared AHB-Lite bus
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    input  m0_req, m0_addr, m1_req, m1_addr, m1_write, m1_size, m1_wdata,
    input  hready, hresp, hrdata,
    output m0_done, m1_done, m0_err, m1_err, rdata, owner,
    output htrans, haddr, hwrite, hsize, hwdata
  );

  modport slave (
    output m0_req, m0_addr, m1_req, m1_addr, m1_write, m1_size, m1_wdata,
    output hready, hresp, hrdata,
    input  m0_done, m1_done, m0_err, m1_err, rdata, owner,
    input  htrans, haddr, hwrite, hsize, hwdata
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Purpose : two-master AHB-Lite arbiter/sequencer; master 0 = instruction fetch
//           (word reads only), master 1 = load/store. One single-beat,
//           non-pipelined transfer at a time: IDLE -> ADDR -> DATA -> RESP.
// Ports   : clk, reset (async, active-high); bus = ahb_bus_arbiter_if.master
//           (m*_req/addr/..., m*_done/err pulses, rdata, owner, htrans/haddr/
//           hwrite/hsize/hwdata out, hready/hresp/hrdata in).
// Latency : zero-wait slave -> done pulse 3 cycles after the granting edge;
//           one extra cycle per hready=0 cycle in ADDR or DATA.
// Backpr. : hready=0 freezes the current phase; requests are only sampled in
//           IDLE, so requesters simply hold req until their done pulse.
// Config  : AHB_ARB_RR_EN defined -> round-robin tie break; undefined ->
//           master 1 priority with STARVE_MAX starvation guard for master 0.
module ahb_bus_arbiter
`ifndef AHB_ARB_RR_EN
  #(parameter int STARVE_MAX = 4)
`endif
(
  input logic               clk,
  input logic               reset,
  ahb_bus_arbiter_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] wdata_q, wdata_d;   // store data held from grant until DATA
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        m0_done_q, m0_done_d;
  logic        m1_done_q, m1_done_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_err_q, m1_err_d;

  logic any_req;
  logic tie_m1;    // who wins when both requesters are high
  logic grant_m1;
  logic grant_vld; // a grant is issued on this edge

  assign any_req   = bus.m0_req | bus.m1_req;
  assign grant_vld = (state_q == ST_IDLE) && any_req;
  assign grant_m1  = bus.m1_req & (~bus.m0_req | tie_m1);

  // ---------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------
`ifdef AHB_ARB_RR_EN
  // Remembers the last granted master; the other one wins the next tie.
  // Resets to 1 so master 0 takes the first tie.
  logic last_q, last_d;

  assign tie_m1 = ~last_q;

  always_comb begin
    last_d = last_q;
    if (grant_vld) begin
      last_d = grant_m1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Counts master-1 grants made while master 0 was waiting; once it reaches
  // the limit, master 0 takes the next tie and the count restarts.
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign tie_m1 = (starve_cnt_q != STARVE_LIM);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_vld) begin
      if (!grant_m1) begin
        starve_cnt_d = 4'd0;
      end else if (bus.m0_req && (starve_cnt_q != STARVE_LIM)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Transfer sequencer. Every output is a flop, so each value is computed
  // one cycle ahead for the state being entered.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    htrans_d  = htrans_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    wdata_d   = wdata_q;
    hwdata_d  = hwdata_q;
    rdata_d   = rdata_q;
    m0_done_d = 1'b0;  // done/err are single-cycle pulses
    m1_done_d = 1'b0;
    m0_err_d  = 1'b0;
    m1_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d  = grant_m1;
          htrans_d = HTRANS_NONSEQ;
          if (grant_m1) begin
            haddr_d  = bus.m1_addr;
            hwrite_d = bus.m1_write;
            hsize_d  = bus.m1_size;
            wdata_d  = bus.m1_wdata;
          end else begin
            // fetch port: always a word read with zero write data
            haddr_d  = bus.m0_addr;
            hwrite_d = 1'b0;
            hsize_d  = HSIZE_WORD;
            wdata_d  = 32'd0;
          end
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (bus.hready) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bus.hready) begin
          rdata_d   = bus.hrdata;
          m0_done_d = ~owner_q;
          m1_done_d = owner_q;
          m0_err_d  = ~owner_q & bus.hresp;
          m1_err_d  = owner_q & bus.hresp;
          hwdata_d  = 32'd0;
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      haddr_q   <= 32'd0;
      hwrite_q  <= 1'b0;
      hsize_q   <= 3'd0;
      wdata_q   <= 32'd0;
      hwdata_q  <= 32'd0;
      rdata_q   <= 32'd0;
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      htrans_q  <= htrans_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      hsize_q   <= hsize_d;
      wdata_q   <= wdata_d;
      hwdata_q  <= hwdata_d;
      rdata_q   <= rdata_d;
      m0_done_q <= m0_done_d;
      m1_done_q <= m1_done_d;
      m0_err_q  <= m0_err_d;
      m1_err_q  <= m1_err_d;
    end
  end

  assign bus.owner   = owner_q;
  assign bus.htrans  = htrans_q;
  assign bus.haddr   = haddr_q;
  assign bus.hwrite  = hwrite_q;
  assign bus.hsize   = hsize_q;
  assign bus.hwdata  = hwdata_q;
  assign bus.rdata   = rdata_q;
  assign bus.m0_done = m0_done_q;
  assign bus.m1_done = m1_done_q;
  assign bus.m0_err  = m0_err_q;
  assign bus.m1_err  = m1_err_q;

  // Only one owner can complete at a time, and err never appears without done.
  a_done_onehot : assert property (@(posedge clk) disable iff (reset)
    !(m0_done_q && m1_done_q));
  a_err_with_done : assert property (@(posedge clk) disable iff (reset)
    (!m0_err_q || m0_done_q) && (!m1_err_q || m1_done_q));

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Two-master AHB-Lite arbiter and transfer sequencer for the processor's shared memory bus. It multiplexes the instruction-fetch port (master 0) and the load/store port (master 1) onto one address/control/data bus. That bus feeds the decoder, slave glue, ROM, RAM and response mux. Each requester gets a single-beat, non-pipelined transfer with a done/err handshake and a registered read-data return.

## Interface
Parameters:
- STARVE_MAX, default 4: in fixed-priority mode, the maximum number of consecutive master-1 grants while master 0 is pending. Legal range 1–15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- m0_req  in  1  fetch request; held high until m0_done.
- m0_addr  in  32  fetch address; word read, hsize fixed to 3'b010.
- m1_req  in  1  load/store request; held high until m1_done.
- m1_addr  in  32  load/store address.
- m1_write  in  1  1 = store, 0 = load.
- m1_size  in  3  AHB hsize encoding: 0 = byte, 1 = half, 2 = word.
- m1_wdata  in  32  store data.
- m0_done, m1_done  out  1  one-cycle completion pulse to the owning master.
- m0_err, m1_err  out  1  asserted together with the matching done when the slave returned an error (hresp=1).
- rdata  out  32  registered hrdata; valid while a done pulse is high.
- owner  out  1  master currently granted; holds its last value while idle.
- htrans  out  2  2'b10 (NONSEQ) in the address phase, 2'b00 (IDLE) otherwise.
- haddr, hwrite, hsize  out  32/1/3  address-phase control.
- hwdata  out  32  write data, driven in the data phase.
- hready, hresp  in  1  slave response from the response mux.
- hrdata  in  32  slave read data from the response mux.

## Operation
- State machine: IDLE → ADDR → DATA → RESP → IDLE.
- **IDLE**
  - Samples m0_req and m1_req.
  - If neither is high, stays in IDLE.
  - Otherwise selects a winner, latches that master's address, write, size and wdata into request registers, sets owner, and goes to ADDR.
- **ADDR**
  - Drives htrans=NONSEQ and haddr/hwrite/hsize from the request registers.
  - On hready=1, goes to DATA.
  - On hready=0, holds all outputs unchanged.
- **DATA**
  - Drives htrans=IDLE and hwdata from the latched wdata.
  - Waits for hready=1, then captures hrdata into rdata and the hresp value into an error flag, and goes to RESP.
- **RESP**
  - Pulses done for the owner for exactly one cycle; err is high in the same cycle if the captured hresp was 1.
  - Returns to IDLE.
- Master-0 transfers always use hwrite=0, hsize=3'b010 and hwdata=0.
- Requester contract: on the clock edge where a master samples done=1, it either drops req or presents its next request. The arbiter samples req only in IDLE, so back-to-back requests are legal. A req asserted during ADDR/DATA/RESP is not seen until IDLE.
- Arbitration (fixed priority, default):
  - Master 1 wins ties, unless starve_cnt == STARVE_MAX, in which case master 0 wins.
  - starve_cnt increments when master 1 is granted while m0_req=1, saturating at STARVE_MAX.
  - starve_cnt clears when master 0 is granted.
- Arbitration never changes during a transfer; no preemption.
- An error response does not retry or stop arbitration; the next IDLE arbitrates normally.

## Timing
- Reset values:
  - state IDLE
  - htrans=2'b00, haddr=0, hwrite=0, hsize=0, hwdata=0
  - rdata=0, all done and err outputs 0
  - owner=0, starve_cnt=0, round-robin pointer = 1 (master 0 wins the first tie)
- Latency with zero-wait slaves: req high at edge 0 → ADDR in cycle 1 → DATA in cycle 2 → done in cycle 3.
- Each hready=0 cycle in ADDR or DATA adds one cycle of latency.
- Throughput is one transfer per 4 cycles when requests arrive back-to-back.
- All outputs are registered (Moore); there is no combinational path from inputs to outputs.
- Reset asserted mid-transfer: immediate return to IDLE and htrans=IDLE; the in-flight transfer is discarded and no done is issued.

## Configuration
- AHB_ARB_RR_EN defined:
  - Round-robin arbitration. On a tie, the master that was not granted last wins.
  - The pointer updates on every grant.
  - starve_cnt and STARVE_MAX are unused and removed.
- Not defined: fixed priority with the starvation counter, as described in Operation.

## Test plan
- Single fetch: m0_req=1, m0_addr=0x0000_0010, slave zero-wait, hrdata=0x1234_5678 → htrans=2'b10 at cycle 1, m0_done=1 at cycle 3, rdata=0x1234_5678, m0_err=0.
- Store with wait states: m1_write=1, m1_size=0, m1_addr=0x1000_0003, m1_wdata=0xAB, hready low for 2 cycles in DATA → hwdata=0xAB held throughout DATA, m1_done at cycle 5.
- Starvation with STARVE_MAX=4: both requests held continuously → grant order M1, M1, M1, M1, M0, M1, …
- Error: hresp=1 with hready=1 in DATA for an m1 load → m1_done=1 and m1_err=1 in the same cycle, and the next pending m0_req is granted in the following IDLE.
- Reset mid-transfer: assert reset during DATA → htrans=0 and all done outputs 0 immediately; after release, a new m0 request completes normally.
- AHB_ARB_RR_EN defined: both requests held continuously → grants alternate M0, M1, M0, M1.
